// File: rtl/holy_axi_mem_pkg.sv
// Shared types and constants for the AXI4 backing-memory slave.
package holy_axi_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_WR_RESP = 2'd2,
    ST_RD_DATA = 2'd3
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Byte address to word index; addresses below the base wrap to a huge index.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    word_index = (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/holy_axi_mem_array.sv
// Word storage: one asynchronous read port, one synchronous byte-enabled write port.
// Contents are never cleared so data survives a reset of the control logic.
module holy_axi_mem_array #(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-lane write: only lanes with their strobe set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/holy_axi_mem_slave.sv
// AXI4 slave memory: serves one INCR burst at a time from an internal word array.
// Writes take priority over reads so an eviction lands before its refill.
module holy_axi_mem_slave
  import holy_axi_mem_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ID_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  state_t              state;
  state_t              state_nx;
  logic                ready_en;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         idx;
  logic [7:0]          cnt;
  logic [7:0]          len;
  logic                err;
  logic                in_range;
  logic [31:0]         mem_rdata;
  logic                aw_hs;
  logic                ar_hs;
  logic                w_beat;
  logic                r_beat;
  logic                mem_we;
  logic                unused_sig;

  // Size and burst type are fixed by the master (32-bit INCR), so they carry no information.
  assign unused_sig = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};

  assign in_range = (idx < 32'(MEM_WORDS));
  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign w_beat   = (state == ST_WR_DATA) && s_axi_wvalid;
  assign r_beat   = (state == ST_RD_DATA) && s_axi_rready;
  assign mem_we   = w_beat && in_range;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs; address channels open only once ready_en is set,
  // which keeps both readies low for the first cycle after reset is released.
  always_comb begin
    state_nx      = state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        s_axi_awready = ready_en;
        s_axi_arready = ready_en && !s_axi_awvalid;
        if (ready_en && s_axi_awvalid) begin
          state_nx = ST_WR_DATA;
        end else if (ready_en && s_axi_arvalid) begin
          state_nx = ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) begin
          state_nx = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && s_axi_rlast) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Transaction control: latched id, beat counter and the sticky write error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en <= 1'b0;
      id       <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        id  <= s_axi_awid;
        cnt <= '0;
        err <= 1'b0;
      end else if (ar_hs) begin
        id  <= s_axi_arid;
        cnt <= '0;
      end else if (w_beat) begin
        cnt <= cnt + 8'd1;
        // Out-of-range beat, early wlast, or reaching the declared length without wlast.
        if (!in_range || (s_axi_wlast && (cnt != len)) || (!s_axi_wlast && (cnt == len))) begin
          err <= 1'b1;
        end
      end else if (r_beat) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Word index and burst length; pure data, loaded on each address handshake.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      idx <= word_index(s_axi_awaddr, BASE_ADDR);
      len <= s_axi_awlen;
    end else if (ar_hs) begin
      idx <= word_index(s_axi_araddr, BASE_ADDR);
      len <= s_axi_arlen;
    end else if (w_beat || r_beat) begin
      idx <= idx + 32'd1;
    end
  end

  holy_axi_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx[ADDR_W-1:0]),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .raddr (idx[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign s_axi_bid   = id;
  assign s_axi_bresp = ((state == ST_WR_RESP) && err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_rid   = id;
  assign s_axi_rlast = (state == ST_RD_DATA) && (cnt == len);
  assign s_axi_rresp = ((state == ST_RD_DATA) && !in_range) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_rdata = ((state == ST_RD_DATA) && in_range) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_holy_axi_mem_slave.sv
// Bench for holy_axi_mem_slave: directed bursts against a word-array model with
// expected R/B response queues checked every cycle the responses are valid.
module tb_holy_axi_mem_slave;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  holy_axi_mem_slave #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .ID_WIDTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] mdl [MEM_WORDS];
  rbeat_t      rq[$];
  bresp_t      bq[$];
  logic [31:0] got_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [1:0]  last_bresp = 2'b11;
  logic [1:0]  last_rresp = 2'b11;
  time         b_time = 0;
  time         ar_time = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Response checker: every valid R/B cycle is compared with the head of the model queue;
  // the head is only consumed on the accepting cycle, so held beats are re-checked.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          check("r_data", rdata, rq[0].data);
          check("r_resp", 32'(rresp), 32'(rq[0].resp));
          check("r_last", 32'(rlast), 32'(rq[0].last));
          check("r_id", 32'(rid), 32'(rq[0].id));
          if (rready) begin
            last_rresp = rresp;
            void'(rq.pop_front());
          end
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          check("b_resp", 32'(bresp), 32'(bq[0].resp));
          check("b_id", 32'(bid), 32'(bq[0].id));
          if (bready) begin
            last_bresp = bresp;
            b_time = $time;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  // Write burst of wd_q/ws_q beats (wlast on the final one); abort_after>0 stops early
  // without collecting a response.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int abort_after);
    bit got;
    bit err;
    int nb;
    int unsigned wi;
    nb = wd_q.size();
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (awready) got = 1'b1;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    check("aw_accept", 32'(got), 32'd1);
    if (!got) return;
    err = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (abort_after != 0 && b == abort_after) break;
      wvalid = 1'b1; wdata = wd_q[b]; wstrb = ws_q[b]; wlast = (b == nb - 1);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) check("w_first_ready_latency", 32'(wready), 32'd1);
        if (wready) got = 1'b1;
        @(posedge clk); #1;
      end
      check("w_accept", 32'(got), 32'd1);
      wi = ((addr - BASE_ADDR) >> 2) + 32'(b);
      if (wi >= MEM_WORDS) err = 1'b1;
      else for (int k = 0; k < 4; k++) if (ws_q[b][k]) mdl[wi][8*k +: 8] = wd_q[b][8*k +: 8];
      if (b == nb - 1) begin
        if (b != int'(len)) err = 1'b1;
      end else if (b == int'(len)) begin
        err = 1'b1;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (abort_after != 0) return;
    bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    bready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c == 0) check("b_latency", 32'(bvalid), 32'd1);
      if (bvalid) got = 1'b1;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    check("b_accept", 32'(got), 32'd1);
  endtask

  // Read burst; rready follows pat[cycle % 4]. Accepted data lands in got_q.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [3:0] pat);
    bit got;
    bit done;
    int nacc;
    int unsigned ri;
    got_q.delete();
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (arready) begin
        got = 1'b1;
        ar_time = $time;
      end
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    check("ar_accept", 32'(got), 32'd1);
    if (!got) return;
    for (int i = 0; i <= int'(len); i++) begin
      ri = ((addr - BASE_ADDR) >> 2) + 32'(i);
      if (ri < MEM_WORDS) rq.push_back('{data: mdl[ri], resp: 2'b00, last: (i == int'(len)), id: id});
      else rq.push_back('{data: 32'd0, resp: 2'b10, last: (i == int'(len)), id: id});
    end
    nacc = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      rready = pat[c % 4];
      @(negedge clk);
      if (c == 0) check("r_first_beat_latency", 32'(rvalid), 32'd1);
      else if (pat == 4'hF) check("r_contiguous", 32'(rvalid), 32'd1);
      if (rvalid && rready) begin
        got_q.push_back(rdata);
        nacc++;
        if (rlast) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check("r_beat_count", 32'(nacc), 32'(int'(len) + 1));
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mdl[i] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_resps", 32'({bresp, rresp}), 32'd0);
    check("rst_ids", 32'({bid, rid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cycle1_awready", 32'(awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_cycle2_awready", 32'(awready), 32'd1);
    check("post_rst_cycle2_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;

    // 8-beat write then read-back
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 8; i++) begin
      wd_q.push_back(32'hA0 + 32'(i));
      ws_q.push_back(4'hF);
    end
    do_write(4'd3, 32'h100, 8'd7, 0);
    check("burst_bresp_lit", 32'(last_bresp), 32'd0);
    do_read(4'd5, 32'h100, 8'd7, 4'hF);
    for (int i = 0; i < 8; i++) check("burst_rdata_lit", got_q[i], 32'hA0 + 32'(i));
    check("burst_rresp_lit", 32'(last_rresp), 32'd0);

    // Byte strobes
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(32'h1122_3344); ws_q.push_back(4'hF);
    do_write(4'd1, 32'h40, 8'd0, 0);
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'b0101);
    do_write(4'd2, 32'h40, 8'd0, 0);
    do_read(4'd1, 32'h40, 8'd0, 4'hF);
    check("strobe_lit", got_q[0], 32'h11FF_33FF);

    // AW and AR in the same cycle
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(32'hCAFE_0001); ws_q.push_back(4'hF);
    wd_q.push_back(32'hCAFE_0002); ws_q.push_back(4'hF);
    fork
      do_write(4'd6, 32'h80, 8'd1, 0);
      do_read(4'd7, 32'h80, 8'd1, 4'hF);
    join
    check("ar_after_b", 32'(ar_time > b_time), 32'd1);
    check("simul_rdata0_lit", got_q[0], 32'hCAFE_0001);
    check("simul_rdata1_lit", got_q[1], 32'hCAFE_0002);

    // Read backpressure 1-0-0-1
    do_read(4'd2, 32'h100, 8'd7, 4'b1001);
    for (int i = 0; i < 8; i++) check("bp_rdata_lit", got_q[i], 32'hA0 + 32'(i));

    // Out-of-range read
    do_read(4'd4, BASE_ADDR + 32'(MEM_WORDS * 4), 8'd0, 4'hF);
    check("oor_rdata_lit", got_q[0], 32'd0);
    check("oor_rresp_lit", 32'(last_rresp), 32'd2);

    // Burst crossing the top of the array
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(32'h5A5A_0000); ws_q.push_back(4'hF);
    wd_q.push_back(32'h5A5A_0001); ws_q.push_back(4'hF);
    do_write(4'd10, 32'h3FFC, 8'd1, 0);
    check("edge_bresp_lit", 32'(last_bresp), 32'd2);
    do_read(4'd11, 32'h3FFC, 8'd1, 4'hF);
    check("edge_rdata_lit", got_q[0], 32'h5A5A_0000);

    // Early wlast: awlen=3, wlast on beat 2
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(32'hB0); ws_q.push_back(4'hF);
    wd_q.push_back(32'hB1); ws_q.push_back(4'hF);
    do_write(4'd8, 32'h200, 8'd3, 0);
    check("short_bresp_lit", 32'(last_bresp), 32'd2);
    do_read(4'd8, 32'h200, 8'd1, 4'hF);
    check("short_rdata0_lit", got_q[0], 32'hB0);
    check("short_rdata1_lit", got_q[1], 32'hB1);

    // Reset in the middle of a write burst
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) begin
      wd_q.push_back(32'hD0 + 32'(i));
      ws_q.push_back(4'hF);
    end
    do_write(4'd9, 32'h300, 8'd3, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_wready", 32'(wready), 32'd0);
    check("midrst_bvalid", 32'(bvalid), 32'd0);
    check("midrst_awready", 32'(awready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_idle_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    do_read(4'd12, 32'h300, 8'd1, 4'hF);
    check("midrst_rdata0_lit", got_q[0], 32'hD0);
    check("midrst_rdata1_lit", got_q[1], 32'hD1);

    repeat (3) @(posedge clk);
    check("r_queue_drained", 32'(rq.size()), 32'd0);
    check("b_queue_drained", 32'(bq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
